parity_frame_rx: RTL

//  Serial receiver for XOR-parity-protected frames: start(0), DATA_W data bits LSB first, parity, stop(1).

---
 rtl/parity_frame_rx_if.sv | 24 ++
 rtl/parity_frame_rx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx_if.sv
// Serial receive link bundle for parity_frame_rx.
// Parameter: DATA_W - data word width.
// Signals: rx_in (serial line, idle high), data_out, data_valid, parity_err, frame_err, busy.
// Modports: master drives rx_in and observes results; slave is the receiver side.
interface parity_frame_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              rx_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output rx_in,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx_in,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Oversampling serial receiver for start/data(LSB first)/parity/stop frames.
// Recovers the data word, checks XOR parity and flags framing errors.
// Ports: clk, rst (async, active high), bus (parity_frame_rx_if.slave):
//   rx_in in, data_out/data_valid/parity_err/frame_err/busy out (all registered).
// Macro PARITY_RX_SYNC_EN: when defined, rx_in passes a 2-flop synchronizer
//   (reset to 1) before the FSM, delaying all sample points by 2 clk.
module parity_frame_rx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    parity_frame_rx_if.slave bus
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift;
    logic              parity_bit;
    logic [DATA_W-1:0] data_q;
    logic              data_valid_q;
    logic              parity_err_q;
    logic              frame_err_q;
    logic              busy_q;
    logic              rx;

`ifdef PARITY_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer; resets to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rx_in};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = bus.rx_in;
`endif

    // Frame FSM with registered outputs; cnt counts clocks within the current bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            parity_bit   <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    // Mid-start re-check rejects glitches shorter than half a bit.
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift <= (shift >> 1) | (DATA_W'(rx) << (DATA_W - 1));
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        parity_bit <= rx;
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx) begin
                            data_q       <= shift;
                            parity_err_q <= ((^shift) ^ parity_bit) != PARITY_ODD;
                            data_valid_q <= 1'b1;
                            state        <= IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a stuck-low line never restarts.
                    if (rx) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
endmodule
